vrf_wb_seq: RTL and testbench

VRF_WB_SEQ -- requirements
Module: vrf_wb_seq

---
 rtl/vrf_wb_seq.sv | 71 +++++++
 tb/tb_vrf_wb_seq.sv | 151 +++++++++++++++
 2 files changed

// File: rtl/vrf_wb_seq.sv
// vrf_wb_seq: vector register-file write-back sequencer; define ALIGN_CHECK_EN to reject misaligned group bases
module vrf_wb_seq #(
    parameter int ADDR_WIDTH = 5,
    parameter int DATA_WIDTH = 64
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [ADDR_WIDTH-1:0] vd_in,
    input  logic [2:0]            vlmul,
    input  logic                  in_valid,
    input  logic [DATA_WIDTH-1:0] in_data,
    output logic                  in_ready,
    output logic                  wr_en,
    output logic [ADDR_WIDTH-1:0] wr_addr,
    output logic [DATA_WIDTH-1:0] wr_data,
    output logic                  idle,
    output logic                  done,
    output logic                  err
);
    typedef enum logic {IDLE, WRITE} state_t;
    state_t state;
    logic [ADDR_WIDTH-1:0] base;
    logic [3:0] n, cnt, n_sz;
    logic bad;
    assign n_sz = vlmul[2] ? 4'd1 : 4'd1 << vlmul[1:0];
    assign in_ready = state == WRITE;
    assign idle = state == IDLE;
`ifdef ALIGN_CHECK_EN
    assign bad = |(vd_in & ADDR_WIDTH'(n_sz - 4'd1));
    // err pulses the cycle after a start is refused for a misaligned base
    always_ff @(posedge clk)
        err <= rst && idle && start && bad;
`else
    assign bad = 1'b0;
    assign err = 1'b0;
`endif
    // group sequencing: latch base/size on start, then emit one registered write per accepted beat
    always_ff @(posedge clk) begin
        if (!rst) begin
            state   <= IDLE;
            base    <= '0;
            n       <= '0;
            cnt     <= '0;
            wr_en   <= 1'b0;
            wr_addr <= '0;
            wr_data <= '0;
            done    <= 1'b0;
        end else begin
            wr_en <= 1'b0;
            done  <= 1'b0;
            if (idle) begin
                if (start && !bad) begin
                    base  <= vd_in;
                    n     <= n_sz;
                    cnt   <= '0;
                    state <= WRITE;
                end
            end else if (in_valid) begin
                wr_en   <= 1'b1;
                wr_addr <= base + ADDR_WIDTH'(cnt);
                wr_data <= in_data;
                cnt     <= cnt + 4'd1;
                if (cnt == n - 4'd1) begin
                    done  <= 1'b1;
                    state <= IDLE;
                end
            end
        end
    end
endmodule

// File: tb/tb_vrf_wb_seq.sv
// tb_vrf_wb_seq: directed-vector bench for vrf_wb_seq
module tb_vrf_wb_seq;
    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        start = 1'b0;
    logic [4:0]  vd_in = '0;
    logic [2:0]  vlmul = '0;
    logic        in_valid = 1'b0;
    logic [63:0] in_data = '0;
    logic        in_ready, wr_en, idle, done, err;
    logic [4:0]  wr_addr;
    logic [63:0] wr_data;
    int checks = 0;
    int errors = 0;
    int writes, dones;

    vrf_wb_seq dut (
        .clk(clk), .rst(rst), .start(start), .vd_in(vd_in), .vlmul(vlmul),
        .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .idle(idle), .done(done), .err(err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_grp(input logic [4:0] vd, input logic [2:0] lm);
        start = 1'b1; vd_in = vd; vlmul = lm; in_valid = 1'b0;
        tick();
        start = 1'b0;
        chk("start_ready", in_ready, 1);
        chk("start_idle", idle, 0);
        chk("start_wr_en", wr_en, 0);
    endtask

    task automatic beat(input logic [63:0] d, input logic [4:0] a, input logic last);
        in_valid = 1'b1; in_data = d;
        tick();
        in_valid = 1'b0;
        chk("beat_wr_en", wr_en, 1);
        chk("beat_addr", wr_addr, a);
        chk("beat_data", wr_data, d);
        chk("beat_done", done, last);
        chk("beat_idle", idle, last);
    endtask

    task automatic reset_vals(input string tag);
        chk({tag, "_idle"}, idle, 1);
        chk({tag, "_wr_en"}, wr_en, 0);
        chk({tag, "_addr"}, wr_addr, 0);
        chk({tag, "_data"}, wr_data, 0);
        chk({tag, "_done"}, done, 0);
        chk({tag, "_err"}, err, 0);
        chk({tag, "_ready"}, in_ready, 0);
    endtask

    initial begin
        in_valid = 1'b1; in_data = 64'hdead;
        tick(); tick();
        reset_vals("rst");
        rst = 1'b1; in_valid = 1'b0;
        tick();

        // base 8, four beats
        start_grp(5'd8, 3'b010);
        for (int k = 0; k < 4; k++) beat(64'hA000 + 64'(k), 5'(8 + k), k == 3);
        in_valid = 1'b1; in_data = 64'hbad;
        tick();
        chk("idle_valid_wr_en", wr_en, 0);
        chk("idle_valid_ready", in_ready, 0);
        in_valid = 1'b0;

        // start/vd/vlmul changes ignored mid-group
        start_grp(5'd0, 3'b010);
        for (int k = 0; k < 4; k++) begin
            start = k < 3; vd_in = 5'd3; vlmul = 3'b001;
            beat(64'hB000 + 64'(k), 5'(k), k == 3);
        end
        start = 1'b0;
        tick();
        chk("ignored_start_idle", idle, 1);

        // gapped beats over a group of 8
        writes = 0; dones = 0;
        start_grp(5'd16, 3'b011);
        for (int k = 0; k < 8; k++) begin
            tick();
            chk("gap_wr_en", wr_en, 0);
            beat(64'hC000 + 64'(k), 5'(16 + k), k == 7);
            writes += int'(wr_en);
            dones += int'(done);
        end
        chk("gap_writes", 64'(writes), 8);
        chk("gap_dones", 64'(dones), 1);

        // vlmul[2] set gives one beat; start on done cycle is accepted
        start_grp(5'd5, 3'b100);
        beat(64'hD005, 5'd5, 1);
        start_grp(5'd6, 3'b000);
        beat(64'hD006, 5'd6, 1);

        // misaligned base
        start = 1'b1; vd_in = 5'd30; vlmul = 3'b010;
        tick();
        start = 1'b0;
`ifdef ALIGN_CHECK_EN
        chk("align_err", err, 1);
        chk("align_idle", idle, 1);
        chk("align_wr_en", wr_en, 0);
        tick();
        chk("align_err_clear", err, 0);
`else
        chk("wrap_err", err, 0);
        chk("wrap_ready", in_ready, 1);
        beat(64'hE000, 5'd30, 0);
        beat(64'hE001, 5'd31, 0);
        beat(64'hE002, 5'd0, 0);
        beat(64'hE003, 5'd1, 1);
`endif

        // reset abandons an active group
        start_grp(5'd8, 3'b010);
        beat(64'hF000, 5'd8, 0);
        beat(64'hF001, 5'd9, 0);
        rst = 1'b0; in_valid = 1'b1; in_data = 64'hF002;
        tick();
        reset_vals("midrst");
        rst = 1'b1;
        for (int k = 0; k < 3; k++) begin
            tick();
            chk("post_rst_wr_en", wr_en, 0);
        end
        chk("post_rst_idle", idle, 1);
        in_valid = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
